decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Stage-2 (instruction decode) of the pipeline; the producing end of the execute-stage interface.
- Decodes a 32-bit RV32I instruction into the control and operand fields the execute stage consumes: `inReg1`, `inReg2`, `imm`, `ALUSrc`, `func7`, `func3`, `AluOp`, plus memory/writeback controls.
- Contains the 32x32 register file (write port driven from writeback) and the ID/EX pipeline register with stall/flush control.

Parameters:
- XLEN, 32, data width of registers, operands and immediate
- NREGS, 32, number of architectural registers; x0 is hardwired to 0

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instr  in  32  instruction from fetch
- instr_valid  in  1  instr is valid this cycle
- stall  in  1  hold the ID/EX register (downstream not ready)
- flush  in  1  squash the instruction entering ID/EX (branch taken)
- wr_en  in  1  register-file write enable (writeback)
- wr_addr  in  5  register-file write address
- wr_data  in  32  register-file write data
- inReg1  out  32  rs1 value
- inReg2  out  32  rs2 value
- imm  out  32  sign-extended immediate
- ALUSrc  out  1  1 = execute uses imm as operand B
- func7  out  7  instr[31:25]
- func3  out  3  instr[14:12]
- AluOp  out  2  00 load/store, 01 branch, 10 R-type ALU
- rd  out  5  destination register
- RegWrite, MemRead, MemWrite, MemToReg, Branch  out  1 each  downstream controls
- ex_valid  out  1  ID/EX holds a real instruction
- illegal  out  1  one-cycle pulse: valid instr had an unsupported opcode

Behaviour:
- Reset: all outputs 0 (`ex_valid=0`, `AluOp=00`, `imm=0`, `illegal=0`). All 32 registers are cleared to 0 on the same edge. Reset overrides stall, flush and wr_en.
- Latency: one cycle. The instruction presented at edge N appears on the outputs after edge N.
- Decode, by opcode instr[6:0]:
  - 0110011 R-type: `AluOp=10`, `ALUSrc=0`, `RegWrite=1`, `imm=0`.
  - 0000011 load: `AluOp=00`, `ALUSrc=1`, `MemRead=1`, `MemToReg=1`, `RegWrite=1`. imm = sext(instr[31:20]).
  - 0100011 store: `AluOp=00`, `ALUSrc=1`, `MemWrite=1`. imm = sext({instr[31:25], instr[11:7]}).
  - 1100011 branch: `AluOp=01`, `ALUSrc=0`, `Branch=1`. imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - Any other opcode: illegal.
- Passthrough: `func7`, `func3` and `rd` are taken directly from instr. `rd` is forced to 0 for store and branch.
- Register file:
  - Read addresses are rs1 = instr[19:15] and rs2 = instr[24:20]. A read of x0 returns 0.
  - Write on the clk edge when `wr_en` is set and `wr_addr` != 0. A write to x0 is ignored.
  - Write-through bypass: if `wr_en` and `wr_addr`==rs (nonzero) in the same cycle, the captured operand is `wr_data`.
  - Writes proceed regardless of stall or flush.
- ID/EX register update, in priority order:
  1. rst.
  2. flush: bubble (`ex_valid=0`, all control outputs 0, `AluOp=00`).
  3. stall: hold all outputs unchanged. `illegal` is forced to 0 while stalled.
  4. Otherwise, if `instr_valid` and the opcode is legal: capture decoded fields, `ex_valid=1`.
  5. Otherwise, if `instr_valid` and the opcode is illegal: bubble, with `illegal=1` for exactly one cycle.
  6. Otherwise: bubble.
- Simultaneous flush and stall: flush wins.
- Bubble: data outputs are don't-care, but must be driven to 0 (no X).

Test Plan:
- Write x5=0x0000_0007, x6=0x0000_0003. Then instr 0x40628433 (sub x8,x5,x6) -> next cycle `inReg1=7`, `inReg2=3`, `func7=0100000`, `func3=000`, `AluOp=10`, `ALUSrc=0`, `RegWrite=1`, `rd=8`, `ex_valid=1`.
- instr 0xFFC2A303 (lw x6,-4(x5)) -> `imm=0xFFFFFFFC`, `ALUSrc=1`, `AluOp=00`, `MemRead=1`, `MemToReg=1`, `rd=6`. Then sw 0xFE62AE23 -> `imm=0xFFFFFFFC`, `MemWrite=1`, `RegWrite=0`, `rd=0`.
- beq x5,x6,-8 (0xFE628CE3) -> `AluOp=01`, `Branch=1`, `imm=0xFFFFFFF8`. With flush=1 on the same edge -> `ex_valid=0`, all controls 0.
- stall=1 for 3 cycles while instr changes -> outputs unchanged. Drop stall -> the current instr is captured on the next edge. stall=1 with flush=1 -> bubble.
- `wr_en=1`, `wr_addr=5`, `wr_data=0xDEADBEEF` in the same cycle as add reading x5 -> `inReg1=0xDEADBEEF`. Write to x0 -> a later read of x0 returns 0.
- Opcode 0x7F valid -> `illegal=1` for one cycle, `ex_valid=0`. rst asserted mid-stream -> all outputs and registers 0 next cycle.

Source files
------------

// File: rtl/decode_stage.sv
// Instruction decode stage: RV32I load/store/branch/R-type decode, 32x32 register file, ID/EX register.
// Latency: one cycle. Stall holds ID/EX (illegal forced low); flush outranks stall and inserts a bubble.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic            instr_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] inReg1,
  output logic [XLEN-1:0] inReg2,
  output logic [XLEN-1:0] imm,
  output logic            ALUSrc,
  output logic [6:0]      func7,
  output logic [2:0]      func3,
  output logic [1:0]      AluOp,
  output logic [4:0]      rd,
  output logic            RegWrite,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            MemToReg,
  output logic            Branch,
  output logic            ex_valid,
  output logic            illegal
);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [XLEN-1:0] r1;
    logic [XLEN-1:0] r2;
    logic [XLEN-1:0] imm;
    logic            alusrc;
    logic [6:0]      f7;
    logic [2:0]      f3;
    logic [1:0]      aluop;
    logic [4:0]      rd;
    logic            regw;
    logic            memr;
    logic            memw;
    logic            m2r;
    logic            br;
    logic            vld;
  } idex_t;

  logic [NREGS-1:0][XLEN-1:0] regs_q;
  idex_t                      idex_q;
  idex_t                      idex_d;
  logic                       illegal_q;
  logic                       legal;
  logic [4:0]                 rs1;
  logic [4:0]                 rs2;
  logic [XLEN-1:0]            rs1_val;
  logic [XLEN-1:0]            rs2_val;

  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];

  // Same-cycle writeback is forwarded so the captured operand is never stale.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0) rs1_val = (wr_en && wr_addr == rs1) ? wr_data : regs_q[rs1];
    if (rs2 != 5'd0) rs2_val = (wr_en && wr_addr == rs2) ? wr_data : regs_q[rs2];
  end

  always_comb begin
    idex_d     = '0;
    legal      = 1'b0;
    idex_d.r1  = rs1_val;
    idex_d.r2  = rs2_val;
    idex_d.f7  = instr[31:25];
    idex_d.f3  = instr[14:12];
    idex_d.rd  = instr[11:7];
    idex_d.vld = 1'b1;
    case (instr[6:0])
      OP_RTYPE: begin
        legal        = 1'b1;
        idex_d.aluop = 2'b10;
        idex_d.regw  = 1'b1;
      end
      OP_LOAD: begin
        legal         = 1'b1;
        idex_d.alusrc = 1'b1;
        idex_d.memr   = 1'b1;
        idex_d.m2r    = 1'b1;
        idex_d.regw   = 1'b1;
        idex_d.imm    = {{(XLEN-12){instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        legal         = 1'b1;
        idex_d.alusrc = 1'b1;
        idex_d.memw   = 1'b1;
        idex_d.rd     = 5'd0;
        idex_d.imm    = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        legal        = 1'b1;
        idex_d.aluop = 2'b01;
        idex_d.br    = 1'b1;
        idex_d.rd    = 5'd0;
        idex_d.imm   = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                        instr[30:25], instr[11:8], 1'b0};
      end
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q    <= '0;
      idex_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (wr_en && wr_addr != 5'd0) regs_q[wr_addr] <= wr_data;
      if (flush) begin
        idex_q    <= '0;
        illegal_q <= 1'b0;
      end else if (stall) begin
        illegal_q <= 1'b0;
      end else if (instr_valid && legal) begin
        idex_q    <= idex_d;
        illegal_q <= 1'b0;
      end else begin
        idex_q    <= '0;
        illegal_q <= instr_valid;
      end
    end
  end

  assign inReg1   = idex_q.r1;
  assign inReg2   = idex_q.r2;
  assign imm      = idex_q.imm;
  assign ALUSrc   = idex_q.alusrc;
  assign func7    = idex_q.f7;
  assign func3    = idex_q.f3;
  assign AluOp    = idex_q.aluop;
  assign rd       = idex_q.rd;
  assign RegWrite = idex_q.regw;
  assign MemRead  = idex_q.memr;
  assign MemWrite = idex_q.memw;
  assign MemToReg = idex_q.m2r;
  assign Branch   = idex_q.br;
  assign ex_valid = idex_q.vld;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected ID/EX contents queued per edge, compared 1ns after the edge.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic        alusrc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [1:0]  aluop;
    logic [4:0]  rd;
    logic        regw;
    logic        memr;
    logic        memw;
    logic        m2r;
    logic        br;
    logic        exv;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, instr_valid, stall, flush, wr_en;
  logic [31:0] instr, wr_data;
  logic [4:0]  wr_addr;
  logic [31:0] inReg1, inReg2, imm;
  logic        ALUSrc, RegWrite, MemRead, MemWrite, MemToReg, Branch, ex_valid, illegal;
  logic [6:0]  func7;
  logic [2:0]  func3;
  logic [1:0]  AluOp;
  logic [4:0]  rd;

  exp_t exp_q[$];
  exp_t obs;
  int   tests = 0;
  int   fails = 0;

  localparam logic [31:0] I_SUB  = 32'h40628433; // sub x8,x5,x6
  localparam logic [31:0] I_LW   = 32'hFFC2A303; // lw  x6,-4(x5)
  localparam logic [31:0] I_SW   = 32'hFE62AE23; // sw  x6,-4(x5)
  localparam logic [31:0] I_BEQ  = 32'hFE628CE3; // beq x5,x6,-8
  localparam logic [31:0] I_ADD9 = 32'h006284B3; // add x9,x5,x6
  localparam logic [31:0] I_ADD0 = 32'h00000533; // add x10,x0,x0
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  decode_stage dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .stall(stall), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .inReg1(inReg1), .inReg2(inReg2), .imm(imm), .ALUSrc(ALUSrc), .func7(func7),
    .func3(func3), .AluOp(AluOp), .rd(rd), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .Branch(Branch),
    .ex_valid(ex_valid), .illegal(illegal)
  );

  always #5 clk = ~clk;

  always_comb begin
    obs        = '0;
    obs.r1     = inReg1;
    obs.r2     = inReg2;
    obs.imm    = imm;
    obs.alusrc = ALUSrc;
    obs.f7     = func7;
    obs.f3     = func3;
    obs.aluop  = AluOp;
    obs.rd     = rd;
    obs.regw   = RegWrite;
    obs.memr   = MemRead;
    obs.memw   = MemWrite;
    obs.m2r    = MemToReg;
    obs.br     = Branch;
    obs.exv    = ex_valid;
    obs.ill    = illegal;
  end

  // One edge; the expectation queued for this edge is popped and compared.
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s scoreboard empty obs=%h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s obs=%h exp=%h", tag, obs, e);
      end
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic v, input logic s, input logic f);
    instr = i; instr_valid = v; stall = s; flush = f;
  endtask

  task automatic wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    wr_en = en; wr_addr = a; wr_data = d;
  endtask

  initial begin
    exp_t bub, e_sub, e_lw, e_sw, e_beq, e_ill, e_add9, e_add0, e_sub0;

    bub = '0;
    e_sub = '0;
    e_sub.r1 = 32'd7; e_sub.r2 = 32'd3; e_sub.f7 = 7'b0100000; e_sub.f3 = 3'b000;
    e_sub.aluop = 2'b10; e_sub.rd = 5'd8; e_sub.regw = 1'b1; e_sub.exv = 1'b1;

    e_lw = '0;
    e_lw.r1 = 32'd7; e_lw.r2 = 32'd0; e_lw.imm = 32'hFFFFFFFC; e_lw.alusrc = 1'b1;
    e_lw.f7 = 7'h7F; e_lw.f3 = 3'b010; e_lw.rd = 5'd6;
    e_lw.regw = 1'b1; e_lw.memr = 1'b1; e_lw.m2r = 1'b1; e_lw.exv = 1'b1;

    e_sw = '0;
    e_sw.r1 = 32'd7; e_sw.r2 = 32'd3; e_sw.imm = 32'hFFFFFFFC; e_sw.alusrc = 1'b1;
    e_sw.f7 = 7'h7F; e_sw.f3 = 3'b010; e_sw.memw = 1'b1; e_sw.exv = 1'b1;

    e_beq = '0;
    e_beq.r1 = 32'd7; e_beq.r2 = 32'd3; e_beq.imm = 32'hFFFFFFF8;
    e_beq.f7 = 7'h7F; e_beq.f3 = 3'b000; e_beq.aluop = 2'b01; e_beq.br = 1'b1; e_beq.exv = 1'b1;

    e_ill = '0;
    e_ill.ill = 1'b1;

    e_add9 = '0;
    e_add9.r1 = 32'hDEADBEEF; e_add9.r2 = 32'd3; e_add9.aluop = 2'b10;
    e_add9.rd = 5'd9; e_add9.regw = 1'b1; e_add9.exv = 1'b1;

    e_add0 = '0;
    e_add0.aluop = 2'b10; e_add0.rd = 5'd10; e_add0.regw = 1'b1; e_add0.exv = 1'b1;

    e_sub0 = e_sub;
    e_sub0.r1 = 32'd0; e_sub0.r2 = 32'd0;

    // Reset, with a competing write and valid instruction that must be ignored.
    rst = 1'b1;
    drive(I_SUB, 1'b1, 1'b0, 1'b0);
    wr(1'b1, 5'd5, 32'h11111111);
    exp_q.push_back(bub); tick("reset");
    rst = 1'b0;

    // Load x5=7 then x6=3 with no instruction flowing.
    drive(I_SUB, 1'b0, 1'b0, 1'b0); wr(1'b1, 5'd5, 32'd7);
    exp_q.push_back(bub); tick("wr_x5_idle");
    wr(1'b1, 5'd6, 32'd3);
    exp_q.push_back(bub); tick("wr_x6_idle");
    wr(1'b0, 5'd0, 32'd0);

    drive(I_SUB, 1'b1, 1'b0, 1'b0); exp_q.push_back(e_sub); tick("sub");
    drive(I_LW,  1'b1, 1'b0, 1'b0); exp_q.push_back(e_lw);  tick("lw");
    drive(I_SW,  1'b1, 1'b0, 1'b0); exp_q.push_back(e_sw);  tick("sw");
    drive(I_BEQ, 1'b1, 1'b0, 1'b0); exp_q.push_back(e_beq); tick("beq");
    drive(I_BEQ, 1'b1, 1'b0, 1'b1); exp_q.push_back(bub);   tick("beq_flush");

    // Stall holds the captured sub while the incoming instruction changes.
    drive(I_SUB, 1'b1, 1'b0, 1'b0); exp_q.push_back(e_sub); tick("pre_stall");
    drive(I_LW,  1'b1, 1'b1, 1'b0); exp_q.push_back(e_sub); tick("stall1");
    drive(I_BEQ, 1'b1, 1'b1, 1'b0); exp_q.push_back(e_sub); tick("stall2");
    drive(I_BAD, 1'b1, 1'b1, 1'b0); exp_q.push_back(e_sub); tick("stall3_illegal_in");
    drive(I_SW,  1'b1, 1'b0, 1'b0); exp_q.push_back(e_sw);  tick("unstall");
    drive(I_LW,  1'b1, 1'b1, 1'b1); exp_q.push_back(bub);   tick("stall_flush");

    // Illegal opcode pulses for one cycle; a following stall must not extend it.
    drive(I_BAD, 1'b1, 1'b0, 1'b0); exp_q.push_back(e_ill); tick("illegal");
    drive(I_BAD, 1'b1, 1'b1, 1'b0); exp_q.push_back(bub);   tick("illegal_stalled");
    drive(I_BAD, 1'b1, 1'b0, 1'b0); exp_q.push_back(e_ill); tick("illegal_again");
    drive(I_BAD, 1'b0, 1'b0, 1'b0); exp_q.push_back(bub);   tick("illegal_not_valid");
    drive(I_SUB, 1'b0, 1'b0, 1'b0); exp_q.push_back(bub);   tick("legal_not_valid");

    // Same-cycle writeback bypass, then x0 writes must stay invisible.
    drive(I_ADD9, 1'b1, 1'b0, 1'b0); wr(1'b1, 5'd5, 32'hDEADBEEF);
    exp_q.push_back(e_add9); tick("bypass_x5");
    drive(I_ADD0, 1'b1, 1'b0, 1'b0); wr(1'b1, 5'd0, 32'h12345678);
    exp_q.push_back(e_add0); tick("x0_no_bypass");
    wr(1'b0, 5'd0, 32'd0);
    exp_q.push_back(e_add0); tick("x0_after_write");
    e_sub.r1 = 32'hDEADBEEF;
    drive(I_SUB, 1'b1, 1'b0, 1'b0); exp_q.push_back(e_sub); tick("x5_written");

    // Mid-stream reset clears outputs and the register file.
    rst = 1'b1; wr(1'b1, 5'd7, 32'hCAFEF00D);
    exp_q.push_back(bub); tick("reset_mid");
    rst = 1'b0; wr(1'b0, 5'd0, 32'd0);
    exp_q.push_back(e_sub0); tick("regs_cleared");

    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_leftover count=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
